// File: rtl/trade_recorder.sv
// Trade recorder: turns engine match events into trade records,
// keeps a circular price history and running display statistics.
module trade_recorder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          match_signal,
    input  logic [7:0]    trade_price,
    input  logic [7:0]    best_bid,
    input  logic [7:0]    best_ask,
    input  logic          freeze,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          new_trade,
    output logic [15:0]   trade_count,
    output logic [7:0]    last_price,
    output logic [7:0]    high_price,
    output logic [7:0]    low_price,
    output logic [7:0]    avg_price,
    output logic [7:0]    spread,
    output logic [AW:0]   fill
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [7:0] mem [DEPTH];

    logic          match_q, match_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [15:0]   count_q, count_d;
    logic [7:0]    last_q, last_d;
    logic [7:0]    high_q, high_d;
    logic [7:0]    low_q, low_d;
    logic [7:0]    avg_q, avg_d;
    logic [7:0]    spread_q, spread_d;
    logic          new_trade_q, new_trade_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    logic          trade_ev;
    logic signed [8:0] diff;
    logic signed [8:0] adj;
    logic [AW-1:0] rd_idx;

    always_comb begin
        trade_ev    = match_signal & ~match_q & ~freeze;
        match_d     = match_signal;
        new_trade_d = trade_ev;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        count_d     = count_q;
        last_d      = last_q;
        high_d      = high_q;
        low_d       = low_q;
        avg_d       = avg_q;

        diff = $signed({1'b0, trade_price}) - $signed({1'b0, avg_q});
        adj  = diff >>> 2;

        spread_d = (best_ask > best_bid) ? best_ask - best_bid : 8'd0;

        // Reads see the pre-write history view.
        rd_idx     = wr_ptr_q - AW'(1) - rd_addr;
        rd_valid_d = {1'b0, rd_addr} < fill_q;
        rd_data_d  = rd_valid_d ? mem[rd_idx] : 8'd0;

        if (trade_ev) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_q != FULL) fill_d = fill_q + (AW+1)'(1);
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            last_d = trade_price;
            if (trade_price > high_q) high_d = trade_price;
            if (trade_price < low_q) low_d = trade_price;
            if (count_q == 16'd0) avg_d = trade_price;
            else avg_d = avg_q + adj[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            match_q     <= 1'b0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            count_q     <= '0;
            last_q      <= '0;
            high_q      <= '0;
            low_q       <= 8'hFF;
            avg_q       <= '0;
            spread_q    <= '0;
            new_trade_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            match_q     <= match_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            last_q      <= last_d;
            high_q      <= high_d;
            low_q       <= low_d;
            avg_q       <= avg_d;
            spread_q    <= spread_d;
            new_trade_q <= new_trade_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && trade_ev) mem[wr_ptr_q] <= trade_price;
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign new_trade   = new_trade_q;
    assign trade_count = count_q;
    assign last_price  = last_q;
    assign high_price  = high_q;
    assign low_price   = low_q;
    assign avg_price   = avg_q;
    assign spread      = spread_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_trade_recorder.sv
// Bench for trade_recorder: cycle scoreboard against a queue-based
// reference plus hand-computed vectors for the corner cases.
module tb_trade_recorder;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          match_signal;
    logic [7:0]    trade_price;
    logic [7:0]    best_bid;
    logic [7:0]    best_ask;
    logic          freeze;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          new_trade;
    logic [15:0]   trade_count;
    logic [7:0]    last_price;
    logic [7:0]    high_price;
    logic [7:0]    low_price;
    logic [7:0]    avg_price;
    logic [7:0]    spread;
    logic [AW:0]   fill;

    always #5 clk = ~clk;

    trade_recorder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .match_signal(match_signal),
        .trade_price(trade_price), .best_bid(best_bid),
        .best_ask(best_ask), .freeze(freeze), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .new_trade(new_trade),
        .trade_count(trade_count), .last_price(last_price),
        .high_price(high_price), .low_price(low_price),
        .avg_price(avg_price), .spread(spread), .fill(fill)
    );

    typedef struct {
        int rd_data, rd_valid, new_trade, count, last;
        int high, low, avg, spread, fill;
    } exp_t;

    typedef struct {
        bit m; int p; int addr;
        int nt, avg, hi, lo, rd, rv;
    } vec_t;

    exp_t sbq[$];
    int   hist[$];
    int   m_md, m_cnt, m_last, m_high, m_low, m_avg;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step(bit rst, bit m, int p, int bid, int ask,
                        bit frz, int addr);
        exp_t e;
        bit   ev;
        int   d, sh;
        @(negedge clk);
        reset        = rst;
        match_signal = m;
        trade_price  = 8'(p);
        best_bid     = 8'(bid);
        best_ask     = 8'(ask);
        freeze       = frz;
        rd_addr      = AW'(addr);
        if (!rst) begin
            hist.delete();
            m_md = 0; m_cnt = 0; m_last = 0;
            m_high = 0; m_low = 255; m_avg = 0;
            e.rd_data = 0; e.rd_valid = 0; e.new_trade = 0;
            e.spread = 0;
        end else begin
            e.rd_valid = (addr < hist.size()) ? 1 : 0;
            e.rd_data  = e.rd_valid ? hist[addr] : 0;
            e.spread   = (ask > bid) ? ask - bid : 0;
            ev = m && !m_md && !frz;
            if (ev) begin
                if (m_cnt == 0) m_avg = p;
                else begin
                    d  = p - m_avg;
                    sh = (d >= 0) ? d / 4 : -((-d + 3) / 4);
                    m_avg = m_avg + sh;
                end
                hist.push_front(p);
                if (hist.size() > DEPTH) void'(hist.pop_back());
                if (m_cnt < 65535) m_cnt++;
                m_last = p;
                if (p > m_high) m_high = p;
                if (p < m_low) m_low = p;
            end
            e.new_trade = ev;
            m_md = m;
        end
        e.count = m_cnt; e.last = m_last; e.high = m_high;
        e.low = m_low; e.avg = m_avg; e.fill = hist.size();
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("rd_data", int'(rd_data), e.rd_data);
        chk("rd_valid", int'(rd_valid), e.rd_valid);
        chk("new_trade", int'(new_trade), e.new_trade);
        chk("trade_count", int'(trade_count), e.count);
        chk("last_price", int'(last_price), e.last);
        chk("high_price", int'(high_price), e.high);
        chk("low_price", int'(low_price), e.low);
        chk("avg_price", int'(avg_price), e.avg);
        chk("spread", int'(spread), e.spread);
        chk("fill", int'(fill), e.fill);
    endtask

    vec_t vt[9];
    int   pulses;

    initial begin
        // m, price, addr -> new, avg, high, low, rd_data, rd_valid
        vt[0] = '{1, 100, 0, 1, 100, 100, 100, 0, 0};
        vt[1] = '{0, 0, 0, 0, 100, 100, 100, 100, 1};
        vt[2] = '{1, 120, 0, 1, 105, 120, 100, 100, 1};
        vt[3] = '{0, 0, 1, 0, 105, 120, 100, 100, 1};
        vt[4] = '{1, 80, 0, 1, 98, 120, 80, 120, 1};
        vt[5] = '{0, 0, 0, 0, 98, 120, 80, 80, 1};
        vt[6] = '{0, 0, 1, 0, 98, 120, 80, 120, 1};
        vt[7] = '{0, 0, 2, 0, 98, 120, 80, 100, 1};
        vt[8] = '{0, 0, 3, 0, 98, 120, 80, 0, 0};

        reset = 1'b0; match_signal = 1'b0; trade_price = '0;
        best_bid = '0; best_ask = '0; freeze = 1'b0; rd_addr = '0;

        step(0, 0, 0, 0, 0, 0, 0);
        chk("reset_low", int'(low_price), 255);
        chk("reset_fill", int'(fill), 0);

        for (int i = 0; i < 10; i++) step(1, 0, 0, 50, 60, 0, 0);
        chk("idle_spread", int'(spread), 10);
        chk("idle_count", int'(trade_count), 0);
        step(1, 0, 0, 70, 60, 0, 0);
        chk("neg_spread", int'(spread), 0);

        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 100, 50, 60, 0, 0);
            pulses += int'(new_trade);
        end
        chk("hold_pulses", pulses, 1);
        chk("hold_rd", int'(rd_data), 100);
        chk("hold_rv", int'(rd_valid), 1);
        chk("hold_avg", int'(avg_price), 100);
        step(1, 0, 0, 50, 60, 0, 0);

        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, vt[i].m, vt[i].p, 50, 60, 0, vt[i].addr);
            chk("vec_new", int'(new_trade), vt[i].nt);
            chk("vec_avg", int'(avg_price), vt[i].avg);
            chk("vec_high", int'(high_price), vt[i].hi);
            chk("vec_low", int'(low_price), vt[i].lo);
            chk("vec_rd", int'(rd_data), vt[i].rd);
            chk("vec_rv", int'(rd_valid), vt[i].rv);
        end

        step(1, 1, 200, 50, 60, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 200, 50, 60, 0, 0);
        chk("frz_count", int'(trade_count), 3);
        chk("frz_last", int'(last_price), 80);
        step(1, 0, 0, 50, 60, 0, 0);
        step(1, 1, 150, 50, 60, 0, 0);
        chk("frz_after_new", int'(new_trade), 1);
        chk("frz_after_count", int'(trade_count), 4);
        step(1, 0, 0, 50, 60, 0, 0);

        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= DEPTH + 3; i++) begin
            step(1, 1, i, 50, 60, 0, 0);
            step(1, 0, 0, 50, 60, 0, 0);
        end
        step(1, 0, 0, 50, 60, 0, 0);
        chk("wrap_rd0", int'(rd_data), DEPTH + 3);
        chk("wrap_fill", int'(fill), DEPTH);
        step(1, 0, 0, 50, 60, 0, DEPTH - 1);
        chk("wrap_rdlast", int'(rd_data), 4);
        chk("wrap_rvlast", int'(rd_valid), 1);

        step(0, 1, 55, 50, 60, 0, 0);
        chk("midrst_count", int'(trade_count), 0);
        chk("midrst_fill", int'(fill), 0);
        chk("midrst_new", int'(new_trade), 0);
        chk("midrst_low", int'(low_price), 255);
        step(1, 1, 77, 50, 60, 0, 0);
        chk("postrst_new", int'(new_trade), 1);
        chk("postrst_last", int'(last_price), 77);
        chk("postrst_count", int'(trade_count), 1);
        step(1, 0, 0, 50, 60, 0, 0);
        chk("postrst_rd", int'(rd_data), 77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
